// File: rtl/core101_regfile_pkg.sv
// Shared constants and helpers for the core integer register file.
// Used by core_regfile and regfile_read_port.
package core101_regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_COUNT      = 2 ** ADDR_WIDTH_DEF;
    localparam int ZERO_REG_ADDR  = 0;

    // Callers zero-extend their index to 32 bits, so one helper serves any ADDR_WIDTH.
    function automatic logic is_zero_addr(input logic [31:0] addr);
        return addr == 32'(ZERO_REG_ADDR);
    endfunction

endpackage

// File: rtl/core_regfile_read_port.sv
// One registered read port of the register file: x0 masking, optional write bypass, hold.
// Build option: define REGFILE_BYPASS_EN for write-first forwarding (default is read-first).
module regfile_read_port
    import core101_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  rd_en_in,
    input  logic [ADDR_WIDTH-1:0] rs_addr_in,
    input  logic                  wr_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic [DATA_WIDTH-1:0] rf_data_in,
    output logic [DATA_WIDTH-1:0] rs_data_out
);

    logic                  w_zero;
    logic [DATA_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH-1:0] r_data;

    assign w_zero = is_zero_addr(32'(rs_addr_in));

`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit = wr_en_in && (wr_addr_in == rs_addr_in) && !w_zero;
    assign w_sel = w_hit ? wr_data_in : rf_data_in;
`else
    // Read-first: the write port is intentionally ignored here.
    logic w_unused_wr;
    assign w_unused_wr = &{1'b0, wr_en_in, wr_addr_in, wr_data_in};
    assign w_sel       = rf_data_in;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_data <= '0;
        end else if (rd_en_in) begin
            r_data <= w_zero ? '0 : w_sel;
        end
    end

    assign rs_data_out = r_data;

endmodule

// File: rtl/core_regfile.sv
// Core integer register file: one write port, two registered read ports, x0 hardwired to zero.
// Build option: REGFILE_BYPASS_EN selects write-first forwarding on the read ports.
module core_regfile
    import core101_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  wr_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  rd_en_in,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_in,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_in,
    output logic [DATA_WIDTH-1:0] rs1_data_out,
    output logic [DATA_WIDTH-1:0] rs2_data_out,
    output logic                  rd_valid_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] w_rs1_raw;
    logic [DATA_WIDTH-1:0] w_rs2_raw;

    // NOTE: the array is reset because the core expects every register to read zero after reset.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en_in && !is_zero_addr(32'(wr_addr_in))) begin
            r_regs[wr_addr_in] <= wr_data_in;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_in;
        end
    end

    assign w_rs1_raw = r_regs[rs1_addr_in];
    assign w_rs2_raw = r_regs[rs2_addr_in];

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rs1_port (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .rd_en_in    (rd_en_in),
        .rs_addr_in  (rs1_addr_in),
        .wr_en_in    (wr_en_in),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .rf_data_in  (w_rs1_raw),
        .rs_data_out (rs1_data_out)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rs2_port (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .rd_en_in    (rd_en_in),
        .rs_addr_in  (rs2_addr_in),
        .wr_en_in    (wr_en_in),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .rf_data_in  (w_rs2_raw),
        .rs_data_out (rs2_data_out)
    );

    assign rd_valid_out = r_rd_valid;

endmodule
